// File: rtl/icache_sa.sv
`default_nettype none
// ============================================================================
//  Module   : icache_sa
//  Purpose  : Set-associative, read-only instruction cache with true-LRU
//             replacement and a word-by-word line fill from memory.
//             Optional hit/miss statistics counters are enabled by defining
//             the macro ICACHE_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module icache_sa #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic        iflush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OFF_BITS = $clog2(WORDS);
    localparam int IDX_BITS = $clog2(SETS);
    localparam int TAG_BITS = 30 - OFF_BITS - IDX_BITS;
    localparam int CW       = (OFF_BITS > 0) ? OFF_BITS : 1;
    localparam int WW       = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                state;
    logic [CW-1:0]         counter;
    logic [TAG_BITS-1:0]   fill_tag;
    logic [IDX_BITS-1:0]   fill_idx;
    logic [WW-1:0]         fill_way;

    logic [WAYS-1:0]       valid [SETS];
    logic [TAG_BITS-1:0]   tags  [SETS][WAYS];
    logic [31:0]           data  [SETS][WAYS][WORDS];

    logic [TAG_BITS-1:0]   req_tag;
    logic [IDX_BITS-1:0]   req_idx;
    logic [CW-1:0]         req_word;
    logic [31:0]           fill_addr;

    logic                  lookup;
    logic                  hit_any;
    logic [WW-1:0]         hit_way;
    logic                  miss;
    logic [WW-1:0]         lru_way;
    logic [WW-1:0]         victim;
    logic                  fill_last;
    logic                  touch_en;
    logic [IDX_BITS-1:0]   touch_set;
    logic [WW-1:0]         touch_way;
    logic [1:0]            addr_unused;

    // Byte offset within a word is irrelevant to a word-wide cache.
    assign addr_unused = imemaddr[1:0];

    assign req_tag = imemaddr[31 -: TAG_BITS];
    assign req_idx = imemaddr[2 + OFF_BITS +: IDX_BITS];

    generate
        if (OFF_BITS > 0) begin : g_word_off
            assign req_word  = imemaddr[2 +: OFF_BITS];
            assign fill_addr = {fill_tag, fill_idx, counter, 2'b00};
        end else begin : g_no_word_off
            assign req_word  = '0;
            assign fill_addr = {fill_tag, fill_idx, 2'b00};
        end
    endgenerate

    // A lookup only happens when idle and the data side is not using memory.
    assign lookup = (state == IDLE) && imemREN && !dmemREN && !dmemWEN && !iflush;

    // Tag compare across all ways of the indexed set.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[req_idx][w] && (tags[req_idx][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    assign ihit     = lookup && hit_any;
    assign miss     = lookup && !hit_any;
    assign imemload = ihit ? data[req_idx][hit_way][req_word] : 32'h0;

    // Victim choice: lowest-numbered invalid way wins, otherwise the LRU way.
    always_comb begin
        victim = lru_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[req_idx][w]) begin
                victim = WW'(w);
            end
        end
    end

    assign fill_last = (state == FILL) && !iwait && (counter == CW'(WORDS - 1));
    assign touch_en  = ihit || fill_last;
    assign touch_set = fill_last ? fill_idx : req_idx;
    assign touch_way = fill_last ? fill_way : hit_way;

    assign iREN  = (state == FILL);
    assign iaddr = (state == FILL) ? fill_addr : 32'h0;

    generate
        if (WAYS > 1) begin : g_lru
            // Age 0 is most recently used, WAYS-1 is least recently used.
            logic [WW-1:0] age [SETS][WAYS];

            // Age update: touched way becomes 0, younger ways age by one.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    for (int s = 0; s < SETS; s++)
                        for (int w = 0; w < WAYS; w++)
                            age[s][w] <= WW'(w);
                end else if (iflush) begin
                    for (int s = 0; s < SETS; s++)
                        for (int w = 0; w < WAYS; w++)
                            age[s][w] <= WW'(w);
                end else if (touch_en) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WW'(w) == touch_way)
                            age[touch_set][w] <= '0;
                        else if (age[touch_set][w] < age[touch_set][touch_way])
                            age[touch_set][w] <= age[touch_set][w] + WW'(1);
                    end
                end
            end

            // The oldest way of the looked-up set is the replacement candidate.
            always_comb begin
                lru_way = '0;
                for (int w = 0; w < WAYS; w++) begin
                    if (age[req_idx][w] == WW'(WAYS - 1))
                        lru_way = WW'(w);
                end
            end
        end else begin : g_no_lru
            assign lru_way = '0;
        end
    endgenerate

    // Controller and storage: miss detection, line fill, flush and reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            counter  <= '0;
            fill_tag <= '0;
            fill_idx <= '0;
            fill_way <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tags[s][w] <= '0;
                    for (int k = 0; k < WORDS; k++)
                        data[s][w][k] <= '0;
                end
            end
        end else if (iflush) begin
            state   <= IDLE;
            counter <= '0;
            for (int s = 0; s < SETS; s++)
                valid[s] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        state    <= FILL;
                        fill_tag <= req_tag;
                        fill_idx <= req_idx;
                        fill_way <= victim;
                        counter  <= '0;
                        // The victim stays invalid until its last word lands.
                        valid[req_idx][victim] <= 1'b0;
                    end
                end
                FILL: begin
                    if (!iwait) begin
                        data[fill_idx][fill_way][counter] <= iload;
                        if (fill_last) begin
                            valid[fill_idx][fill_way] <= 1'b1;
                            tags[fill_idx][fill_way]  <= fill_tag;
                            counter                   <= '0;
                            state                     <= IDLE;
                        end else begin
                            counter <= counter + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    // Statistics: one count per hit cycle and per line fill started.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (ihit) hit_count  <= hit_count + 32'h1;
            if (miss) miss_count <= miss_count + 32'h1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_sa.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_sa
//  Purpose  : Scoreboard bench for icache_sa: a memory model answers fills,
//             expected fill addresses and hit data are queued by the stimulus
//             and consumed by independent monitors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache_sa;

    localparam int WORDS = 2;

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dmemREN;
    logic        dmemWEN;
    logic        iflush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int          checks = 0;
    int          errors = 0;
    int          wait_cycles = 0;
    logic [31:0] exp_data[$];
    logic [31:0] exp_addr[$];

    icache_sa #(.SETS(8), .WAYS(2), .WORDS(WORDS)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .dmemREN  (dmemREN),
        .dmemWEN  (dmemWEN),
        .iflush   (iflush),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory contents: a fixed, easily recognised function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign iload = mem_word(iaddr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Hit monitor: every ihit must carry the next expected instruction word.
    initial begin
        forever begin
            @(negedge CLK);
            if (ihit) begin
                check("ihit_gating", {31'b0, dmemREN | dmemWEN | iflush | RST}, 32'h0);
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_hit actual=%h required=no_hit", imemload);
                end else begin
                    check("imemload", imemload, exp_data.pop_front());
                end
            end
        end
    end

    // Memory model: checks fill addresses, inserts wait states, counts transfers.
    initial begin
        int  wcnt;
        bit  restart;
        wcnt  = 0;
        iwait = 1'b0;
        forever begin
            @(negedge CLK);
            restart = !iREN || !iwait;
            if (iREN) begin
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_iREN actual=%h required=no_request", iaddr);
                end else begin
                    check("iaddr", iaddr, exp_addr[0]);
                    if (!iwait) void'(exp_addr.pop_front());
                end
            end
            @(posedge CLK);
            #1;
            if (restart) wcnt = 0;
            if (iREN && (wcnt < wait_cycles)) begin
                iwait = 1'b1;
                wcnt++;
            end else begin
                iwait = 1'b0;
            end
        end
    end

    // Issue one read and hold it until ihit; exp_lat is cycles before the hit.
    task automatic do_read(input logic [31:0] a, input int exp_lat);
        int          c;
        bit          got;
        logic [31:0] base;
        exp_data.push_back(mem_word(a & ~32'h3));
        if (exp_lat > 0) begin
            base = a & ~32'(WORDS * 4 - 1);
            for (int k = 0; k < WORDS; k++) exp_addr.push_back(base + 32'(4 * k));
        end
        imemREN  = 1'b1;
        imemaddr = a;
        c   = 0;
        got = 0;
        while (!got && c < 300) begin
            @(negedge CLK);
            if (ihit) got = 1;
            else begin
                c++;
                @(posedge CLK);
                #1;
            end
        end
        check($sformatf("latency_%h", a), 32'(c), 32'(exp_lat));
        @(posedge CLK);
        #1;
        imemREN = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        RST      = 1'b1;
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        dmemREN  = 1'b0;
        dmemWEN  = 1'b0;
        iflush   = 1'b0;

        // Outputs quiet while reset is held, even with a request present.
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ihit", {31'b0, ihit}, 32'h0);
        check("rst_imemload", imemload, 32'h0);
        check("rst_iREN", {31'b0, iREN}, 32'h0);
        check("rst_iaddr", iaddr, 32'h0);
        imemREN = 1'b0;
        RST     = 1'b0;
        @(posedge CLK);
        #1;

        // Cold miss, then same-line hit.
        do_read(32'h0000_0040, 1 + WORDS);
        do_read(32'h0000_0044, 0);
`ifdef ICACHE_STATS_EN
        check("miss_count", miss_count, 32'd1);
        check("hit_count", hit_count, 32'd2);
`endif

        // LRU replacement within set 0.
        do_read(32'h0000_0140, 1 + WORDS);
        do_read(32'h0000_0040, 0);
        do_read(32'h0000_0240, 1 + WORDS);
        do_read(32'h0000_0044, 0);
        do_read(32'h0000_0144, 1 + WORDS);
        do_read(32'h0000_0040, 0);

        // Data-side activity blocks the lookup.
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        dmemWEN  = 1'b1;
        @(negedge CLK);
        check("dmem_block_ihit", {31'b0, ihit}, 32'h0);
        check("dmem_block_load", imemload, 32'h0);
        @(posedge CLK);
        #1;
        dmemWEN = 1'b0;
        imemREN = 1'b0;

        // Slow memory with data-side traffic in the middle of the fill.
        wait_cycles = 5;
        fork
            do_read(32'h0000_0188, 1 + WORDS * 6);
            begin
                repeat (3) @(posedge CLK);
                #1;
                dmemREN = 1'b1;
                repeat (5) @(posedge CLK);
                #1;
                dmemREN = 1'b0;
            end
        join
        wait_cycles = 0;
        do_read(32'h0000_018C, 0);

        // Flush: no hit in the flush cycle, then the line must refill.
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        iflush   = 1'b1;
        @(negedge CLK);
        check("flush_ihit", {31'b0, ihit}, 32'h0);
        @(posedge CLK);
        #1;
        iflush  = 1'b0;
        imemREN = 1'b0;
        do_read(32'h0000_0040, 1 + WORDS);

        // Reset in the middle of a fill drops the request at once.
        wait_cycles = 3;
        exp_addr.push_back(32'h80);
        exp_addr.push_back(32'h84);
        imemREN  = 1'b1;
        imemaddr = 32'h80;
        repeat (6) @(posedge CLK);
        #1;
        check("prefill_iREN", {31'b0, iREN}, 32'h1);
        RST = 1'b1;
        #1;
        check("midrst_iREN", {31'b0, iREN}, 32'h0);
        check("midrst_iaddr", iaddr, 32'h0);
        check("midrst_ihit", {31'b0, ihit}, 32'h0);
        exp_addr.delete();
        imemREN = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        wait_cycles = 0;
        do_read(32'h0000_0080, 1 + WORDS);
        do_read(32'h0000_0040, 1 + WORDS);

        repeat (2) @(posedge CLK);
        check("leftover_data", 32'(exp_data.size()), 32'h0);
        check("leftover_addr", 32'(exp_addr.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
